lcd_reader: RTL and testbench
=============================

Name: lcd_reader

Overview:
- Read-side companion to the character-LCD writer. Performs one HD44780-style 4-bit-mode read transaction on the SF_D[11:8] / LCD_E / LCD_RS / LCD_RW interface.
- Transaction type is either a busy-flag/address-counter read (RS=0) or a DDRAM/CGRAM data read (RS=1).
- Reassembles the two nibbles into a byte for the CPU side.
- Sits beside the LCD writer on the 50 MHz clock. Top level muxes lcd_e/lcd_rs/lcd_rw between writer and reader, and tri-states the FPGA SF_D drivers whenever reader busy=1.

Parameters:
T_AS, 2, cycles RS/RW setup before first E rise (≥40 ns at 50 MHz)
T_EH, 12, cycles E held high per nibble (≥230 ns)
T_EL, 50, cycles E low between upper and lower nibble (≥1 µs)
T_H, 1, cycles RS/RW held after final E fall
(all parameters legal range 1..255; internal cycle counter 8 bits)

Ports:
clk  input  1  system clock (50 MHz)
reset  input  1  asynchronous, active-high reset
req  input  1  start a read; sampled only in IDLE
rs  input  1  register select for the read: 0 = busy flag/address, 1 = data; latched with req
sf_d_in  input  4  LCD data nibble from pad input buffer (SF_D[11:8])
lcd_e  output  1  LCD enable strobe
lcd_rs  output  1  LCD register select
lcd_rw  output  1  LCD read/write; 1 = read
busy  output  1  transaction in progress; top must not drive SF_D
done  output  1  one-cycle pulse, rdata valid
rdata  output  8  assembled byte {upper nibble, lower nibble}

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction):
  - state=IDLE, counter=0.
  - lcd_e=0, lcd_rs=0, lcd_rw=0, busy=0, done=0, rdata=8'h00.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, SETUP, HI1, GAP, HI2, HOLD, DONE.
- IDLE:
  - lcd_e=0, lcd_rw=0, lcd_rs=0, busy=0.
  - req=1 at edge k: latch rs, enter SETUP.
  - From cycle k+1: busy=1, lcd_rw=1, lcd_rs=latched rs.
- SETUP: T_AS cycles, lcd_e=0 → HI1.
- HI1:
  - lcd_e=1 for exactly T_EH cycles.
  - sf_d_in sampled on the clock edge ending the last HI1 cycle, stored as the upper nibble.
  - Then → GAP.
- GAP: lcd_e=0 for exactly T_EL cycles → HI2.
- HI2:
  - lcd_e=1 for exactly T_EH cycles.
  - sf_d_in sampled on the edge ending the last HI2 cycle, stored as the lower nibble.
  - Then → HOLD.
- HOLD: lcd_e=0, lcd_rw=1, lcd_rs held, for T_H cycles → DONE.
- DONE (one cycle):
  - done=1; rdata={upper, lower}, updated on entry to DONE.
  - lcd_rw=0, lcd_rs=0, busy=0.
  - Next cycle → IDLE.
- Latency: done high in cycle k+1+T_AS+2·T_EH+T_EL+T_H after the req-sampling edge k. With defaults this is k+78.
- rdata holds its value until the next DONE. It is not cleared on new req.
- lcd_rw and lcd_rs are stable for the whole period that lcd_e=1. They never change in the same cycle as an lcd_e edge.
- req while busy=1, or in the DONE cycle: ignored, not queued. req held continuously starts a new read in the first IDLE cycle after DONE.
- rs changes after the req edge have no effect on the ongoing transaction.
- sf_d_in is not synchronised internally. The sample point is ≥T_EH−1 cycles after E rise, so data is stable by LCD timing.

Test Plan:
- RS=0 read: req pulse at cycle 10 with rs=0; LCD model returns 4'hB during first E-high and 4'h5 during second → lcd_rw=1 from cycle 11, lcd_rs=0, done at cycle 88, rdata=8'hB5, busy low at cycle 88.
- RS=1 read with waveform check: req with rs=1; model returns 4'h4 then 4'h1 → rdata=8'h41, lcd_rs=1 throughout. Verify each E-high width is exactly 12 cycles, gap exactly 50 cycles, 2 cycles from rw rise to first E rise, and 1 cycle from last E fall to rw fall.
- Ignored req: extra req pulses at cycles 20 and 60 during an active read, plus a req in the DONE cycle → exactly one done pulse and no second E burst. A req one cycle after DONE starts a new read.
- Reset mid-HI1: assert reset while lcd_e=1 → lcd_e, lcd_rw, busy, done fall immediately (asynchronously) and rdata=8'h00. After reset release, an rs=0 read returns the correct 8'h80 (busy flag set).
- Back-to-back with held req: req held high for 200 cycles with model data 8'h12 then 8'h34 → two done pulses 79 cycles apart, rdata=8'h12 then 8'h34. The previous value holds between done pulses.
- Parameter override (T_AS=1, T_EH=1, T_EL=1, T_H=1): done exactly 6 cycles after req edge, with E pulses of one cycle each.

Source files
------------

// File: rtl/lcd_reader.sv
// lcd_reader: one HD44780 4-bit-mode read (busy/address or data)
// on SF_D[11:8], reassembling the two nibbles into a byte.
module lcd_reader #(
  parameter int unsigned T_AS = 2,
  parameter int unsigned T_EH = 12,
  parameter int unsigned T_EL = 50,
  parameter int unsigned T_H  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       rs,
  input  logic [3:0] sf_d_in,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HI1,
    S_GAP,
    S_HI2,
    S_HOLD,
    S_DONE
  } state_t;

  // Counter reload values: a phase of N cycles loads N-1
  // and leaves when the counter reaches zero.
  localparam logic [7:0] C_AS = 8'(T_AS - 1);
  localparam logic [7:0] C_EH = 8'(T_EH - 1);
  localparam logic [7:0] C_EL = 8'(T_EL - 1);
  localparam logic [7:0] C_H  = 8'(T_H - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [3:0] upper;
  logic [3:0] lower;
  logic       last;

  assign last = (cnt == 8'd0);

  // Sequencer: every output is registered alongside the state,
  // so lcd_rs/lcd_rw only move in cycles where lcd_e is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= 8'd0;
      upper  <= 4'h0;
      lower  <= 4'h0;
      lcd_e  <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_rw <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      rdata  <= 8'h00;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req) begin
            state  <= S_SETUP;
            cnt    <= C_AS;
            busy   <= 1'b1;
            lcd_rw <= 1'b1;
            lcd_rs <= rs;
          end
        end
        S_SETUP: begin
          if (last) begin
            state <= S_HI1;
            cnt   <= C_EH;
            lcd_e <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_HI1: begin
          if (last) begin
            state <= S_GAP;
            cnt   <= C_EL;
            lcd_e <= 1'b0;
            upper <= sf_d_in;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_GAP: begin
          if (last) begin
            state <= S_HI2;
            cnt   <= C_EH;
            lcd_e <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_HI2: begin
          if (last) begin
            state <= S_HOLD;
            cnt   <= C_H;
            lcd_e <= 1'b0;
            lower <= sf_d_in;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_HOLD: begin
          if (last) begin
            state  <= S_DONE;
            cnt    <= 8'd0;
            done   <= 1'b1;
            busy   <= 1'b0;
            lcd_rw <= 1'b0;
            lcd_rs <= 1'b0;
            rdata  <= {upper, lower};
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          cnt    <= 8'd0;
          lcd_e  <= 1'b0;
          lcd_rs <= 1'b0;
          lcd_rw <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// tb_lcd_reader: random and directed reads of two lcd_reader
// instances against a cycle-offset reference model.
module tb_lcd_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       rs;
  logic [3:0] sf_d_in;

  logic       e0, rs0, rw0, b0, d0;
  logic [7:0] rd0;
  logic       e1, rs1, rw1, b1, d1;
  logic [7:0] rd1;

  lcd_reader u_dflt (
    .clk(clk), .reset(reset), .req(req), .rs(rs),
    .sf_d_in(sf_d_in),
    .lcd_e(e0), .lcd_rs(rs0), .lcd_rw(rw0),
    .busy(b0), .done(d0), .rdata(rd0)
  );

  lcd_reader #(
    .T_AS(1), .T_EH(1), .T_EL(1), .T_H(1)
  ) u_fast (
    .clk(clk), .reset(reset), .req(req), .rs(rs),
    .sf_d_in(sf_d_in),
    .lcd_e(e1), .lcd_rs(rs1), .lcd_rw(rw1),
    .busy(b1), .done(d1), .rdata(rd1)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model configuration / state
  int         sel;
  int         p_as, p_eh, p_el, p_h;
  bit         active;
  int         age;
  logic       rs_c;
  logic [3:0] hi_c, lo_c;
  logic [7:0] rexp;
  logic [3:0] hi_q[$];
  logic [3:0] lo_q[$];
  bit         req_hold, req_once;
  int         req_pct;
  int         rs_force;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] other(input logic [3:0] a,
                                       input logic [3:0] b);
    logic [3:0] v;
    v = 4'($urandom_range(15));
    while (v == a || v == b) v = v + 4'd1;
    return v;
  endfunction

  function automatic logic [12:0] observed();
    if (sel == 1) return {e1, rs1, rw1, b1, d1, rd1};
    return {e0, rs0, rw0, b0, d0, rd0};
  endfunction

  function automatic bit in_hi(input int a);
    return active && a >= 1 + p_as && a <= p_as + p_eh;
  endfunction

  function automatic bit in_lo(input int a);
    return active && a >= 1 + p_as + p_eh + p_el &&
           a <= p_as + 2 * p_eh + p_el;
  endfunction

  // One cycle: check outputs of the current cycle, then drive
  // inputs that the next rising edge will sample.
  task automatic step();
    int         len;
    logic       e, b, d;
    logic [12:0] ex;
    @(negedge clk);
    len = 1 + p_as + 2 * p_eh + p_el + p_h;
    if (active) begin
      age++;
      if (age > len) active = 0;
    end
    if (active && age == len) rexp = {hi_c, lo_c};
    b  = active && age >= 1 && age < len;
    e  = in_hi(age) || in_lo(age);
    d  = active && age == len;
    ex = {e, b ? rs_c : 1'b0, b, b, d, rexp};
    chk("cycle", {3'b0, observed()}, {3'b0, ex});
    if (in_hi(age)) sf_d_in = hi_c;
    else if (in_lo(age)) sf_d_in = lo_c;
    else sf_d_in = other(hi_c, lo_c);
    req = req_hold || req_once || ($urandom_range(99) < req_pct);
    req_once = 0;
    if (req && rs_force >= 0) rs = rs_force[0];
    else rs = 1'($urandom_range(1));
    if (req && !active) begin
      active = 1;
      age    = 0;
      rs_c   = rs;
      if (hi_q.size() > 0) begin
        hi_c = hi_q.pop_front();
        lo_c = lo_q.pop_front();
      end else begin
        hi_c = 4'($urandom_range(15));
        lo_c = 4'($urandom_range(15));
      end
    end
  endtask

  task automatic do_reset(input int which);
    @(negedge clk);
    reset    = 1'b1;
    req      = 1'b0;
    req_hold = 0;
    req_once = 0;
    req_pct  = 0;
    rs_force = -1;
    active   = 0;
    age      = 0;
    rexp     = 8'h00;
    sel      = which;
    if (which == 1) begin
      p_as = 1; p_eh = 1; p_el = 1; p_h = 1;
    end else begin
      p_as = 2; p_eh = 12; p_el = 50; p_h = 1;
    end
    step();
    step();
    reset = 1'b0;
  endtask

  int n;
  int dprev;
  int gap;

  initial begin
    reset = 1'b1; req = 1'b0; rs = 1'b0; sf_d_in = 4'h0;
    hi_c = 4'h0; lo_c = 4'h0; rs_c = 1'b0;
    do_reset(0);
    chk("reset_state", {3'b0, observed()}, 16'h0000);

    // busy/address read with nibbles B then 5
    for (int i = 0; i < 9; i++) step();
    hi_q.push_back(4'hB); lo_q.push_back(4'h5);
    rs_force = 0; req_once = 1;
    for (int i = 0; i < 85; i++) step();
    chk("rd_b5", {8'h0, rd0}, 16'h00B5);

    // data read with nibbles 4 then 1
    hi_q.push_back(4'h4); lo_q.push_back(4'h1);
    rs_force = 1; req_once = 1;
    for (int i = 0; i < 85; i++) step();
    chk("rd_41", {8'h0, rd0}, 16'h0041);

    // stray requests during the read, in DONE and just after
    hi_q.push_back(4'hC); lo_q.push_back(4'h3);
    hi_q.push_back(4'h9); lo_q.push_back(4'hE);
    rs_force = -1; req_once = 1;
    step();
    for (int i = 1; i < 170; i++) begin
      if (i == 10 || i == 50 || i == 78 || i == 79)
        req_once = 1;
      step();
    end
    chk("rd_9e", {8'h0, rd0}, 16'h009E);

    // asynchronous reset in the middle of the first E pulse
    hi_q.push_back(4'h7); lo_q.push_back(4'h7);
    req_once = 1;
    n = 0;
    while (!(active && age == p_as + 4) && n < 40) begin
      step();
      n++;
    end
    chk("reached_hi1", {15'h0, e0}, 16'h0001);
    #2 reset = 1'b1;
    #1 chk("rst_async", {3'b0, observed()}, 16'h0000);
    active = 0;
    rexp   = 8'h00;
    step();
    step();
    reset = 1'b0;
    hi_q.push_back(4'h8); lo_q.push_back(4'h0);
    rs_force = 0; req_once = 1;
    for (int i = 0; i < 85; i++) step();
    chk("rd_80", {8'h0, rd0}, 16'h0080);

    // held request: back-to-back reads 79 cycles apart
    hi_q.push_back(4'h1); lo_q.push_back(4'h2);
    hi_q.push_back(4'h3); lo_q.push_back(4'h4);
    rs_force = -1; req_hold = 1;
    dprev = -1; gap = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (d0) begin
        if (dprev < 0) chk("first_12", {8'h0, rd0}, 16'h0012);
        else if (gap < 0) begin
          gap = i - dprev;
          chk("second_34", {8'h0, rd0}, 16'h0034);
        end
        dprev = i;
      end
    end
    chk("done_gap", 16'(gap), 16'd79);
    req_hold = 0;
    for (int i = 0; i < 100; i++) step();

    // random traffic, default timing
    req_pct = 4;
    for (int i = 0; i < 3000; i++) step();
    req_pct = 0;
    for (int i = 0; i < 100; i++) step();

    // minimal timing instance
    do_reset(1);
    hi_q.push_back(4'hA); lo_q.push_back(4'h6);
    rs_force = 1; req_once = 1;
    step();
    n = 0;
    while (!d1 && n < 20) begin
      step();
      n++;
    end
    chk("fast_latency", 16'(n), 16'd6);
    chk("fast_rd", {8'h0, rd1}, 16'h00A6);
    rs_force = -1;
    req_pct = 30;
    for (int i = 0; i < 1500; i++) step();
    req_pct = 0;
    for (int i = 0; i < 10; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
